// File: rtl/verifier_beta_seq_pkg.sv
// Shared field constants for the verifier datapath.
package verifier_beta_seq_pkg;

    localparam int unsigned F_NBITS = 16;
    localparam logic [F_NBITS-1:0] F_PRIME = 16'd65521;

endpackage

// File: rtl/verifier_beta_seq.sv
// Sequencer that walks one beta element through all coordinates of z and w,
// optionally finishing with a scale multiply through the element's mul_beta path.
module verifier_beta_seq
    import verifier_beta_seq_pkg::*;
#(
    parameter int unsigned NVARS    = 8,
    parameter int unsigned CNT_BITS = $clog2(NVARS) + 1
) (
    input  logic                          clk,
    input  logic                          rstb,
    input  logic                          en,
    input  logic                          scale_en,
    input  logic [F_NBITS-1:0]            scale_in,
    input  logic [NVARS-1:0][F_NBITS-1:0] z_vals,
    input  logic [NVARS-1:0][F_NBITS-1:0] w_vals,
    output logic                          elem_en,
    output logic                          elem_restart,
    output logic                          elem_mul_beta,
    output logic [F_NBITS-1:0]            elem_w,
    output logic [F_NBITS-1:0]            elem_z,
    output logic [1:0][F_NBITS-1:0]       elem_mb_in,
    input  logic                          elem_ready,
    input  logic [F_NBITS-1:0]            elem_beta,
    output logic                          ready,
    output logic                          done_pulse,
    output logic [F_NBITS-1:0]            beta_out
);

    localparam int unsigned IDX_BITS = (NVARS > 1) ? $clog2(NVARS) : 1;
    localparam logic [CNT_BITS-1:0] LAST_I = CNT_BITS'(NVARS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StScIssue,
        StScWait
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_BITS-1:0]       i_q, i_d;
    logic                      scale_q, scale_d;
    logic                      en_dly;
    logic                      start;
    logic [F_NBITS-1:0]        beta_q, beta_d;
    logic                      done_q, done_d;
    logic [1:0][F_NBITS-1:0]   mb_q, mb_d;

    // en_dly resets high so an en held through reset is not seen as a rising edge.
    assign start = en & ~en_dly;
    assign ready = (state_q == StIdle) & ~start;

    always_comb begin
        state_d       = state_q;
        i_d           = i_q;
        scale_d       = scale_q;
        beta_d        = beta_q;
        done_d        = 1'b0;
        mb_d          = mb_q;
        elem_en       = 1'b0;
        elem_restart  = 1'b0;
        elem_mul_beta = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StIssue;
                    i_d     = '0;
                    scale_d = scale_en;
                end
            end
            StIssue: begin
                elem_en      = 1'b1;
                elem_restart = (i_q == '0);
                state_d      = StWait;
            end
            StWait: begin
                if (elem_ready) begin
                    if (i_q < LAST_I) begin
                        i_d     = i_q + 1'b1;
                        state_d = StIssue;
                    end else if (scale_q) begin
                        // Capture operands so they stay put while the element recomputes beta.
                        mb_d    = {scale_in, elem_beta};
                        state_d = StScIssue;
                    end else begin
                        beta_d  = elem_beta;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StScIssue: begin
                elem_en       = 1'b1;
                elem_mul_beta = 1'b1;
                state_d       = StScWait;
            end
            StScWait: begin
                if (elem_ready) begin
                    beta_d  = elem_beta;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= StIdle;
            i_q     <= '0;
            scale_q <= 1'b0;
            en_dly  <= 1'b1;
            beta_q  <= '0;
            done_q  <= 1'b0;
            mb_q    <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            scale_q <= scale_d;
            en_dly  <= en;
            beta_q  <= beta_d;
            done_q  <= done_d;
            mb_q    <= mb_d;
        end
    end

    assign elem_w     = (state_q == StIdle) ? '0 : w_vals[i_q[IDX_BITS-1:0]];
    assign elem_z     = (state_q == StIdle) ? '0 : z_vals[i_q[IDX_BITS-1:0]];
    assign elem_mb_in = mb_q;
    assign done_pulse = done_q;
    assign beta_out   = beta_q;

endmodule
